// File: rtl/udma_tx_rr_arbiter.sv
// udma_tx_rr_arbiter: round-robin share of one L2 read port among N_CH uDMA TX channels
// Ports: sys_clk_i/rst_i clock and sync active-high reset; req_i/addr_i/datasize_i/gnt_o
// channel request side; l2_req_o/l2_addr_o/l2_datasize_o/l2_gnt_i L2 address handshake;
// l2_r_valid_i/l2_r_data_i/l2_r_ready_o L2 response; r_valid_o/r_data_o/r_ready_i channel
// responses; outstd_o outstanding reads; err_o sticky response-without-owner flag.
// Optional macro UDMA_ARB_PRIO_EN adds prio_i to restrict selection to prioritised channels.
module udma_tx_rr_arbiter #(
  parameter int N_CH           = 4,
  parameter int L2_AWIDTH_NOAL = 19,
  parameter int MAX_OUTSTD     = 4
) (
  input  logic                           sys_clk_i,
  input  logic                           rst_i,
  input  logic [N_CH-1:0]                req_i,
  input  logic [N_CH*L2_AWIDTH_NOAL-1:0] addr_i,
  input  logic [N_CH*2-1:0]              datasize_i,
`ifdef UDMA_ARB_PRIO_EN
  input  logic [N_CH-1:0]                prio_i,
`endif
  output logic [N_CH-1:0]                gnt_o,
  output logic                           l2_req_o,
  output logic [L2_AWIDTH_NOAL-1:0]      l2_addr_o,
  output logic [1:0]                     l2_datasize_o,
  input  logic                           l2_gnt_i,
  input  logic                           l2_r_valid_i,
  input  logic [31:0]                    l2_r_data_i,
  output logic                           l2_r_ready_o,
  output logic [N_CH-1:0]                r_valid_o,
  output logic [31:0]                    r_data_o,
  input  logic [N_CH-1:0]                r_ready_i,
  output logic [$clog2(MAX_OUTSTD):0]    outstd_o,
  output logic                           err_o
);
  localparam int IDW = $clog2(N_CH);
  localparam int PW  = $clog2(MAX_OUTSTD);
  localparam int CW  = PW + 1;
  logic [IDW-1:0] ptr_q, ptr_d, lock_id_q, sel, sel_rr;
  logic           lock_q, err_q, err_d;
  logic [IDW-1:0] fifo_q [MAX_OUTSTD];
  logic [PW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0] elig, cand;
  logic full, empty, hs, pop;
  logic [IDW-1:0] head;
  assign full  = cnt_q == CW'(MAX_OUTSTD);
  assign empty = cnt_q == '0;
  assign elig  = req_i & {N_CH{~full}};
`ifdef UDMA_ARB_PRIO_EN
  assign cand = |(elig & prio_i) ? elig & prio_i : elig;
`else
  assign cand = elig;
`endif
  // lowest offset from ptr wins, so scan offsets downwards and let the last hit stick
  always_comb begin
    sel_rr = ptr_q;
    for (int i = N_CH - 1; i >= 0; i--)
      if (cand[(int'(ptr_q) + i) % N_CH]) sel_rr = IDW'((int'(ptr_q) + i) % N_CH);
  end
  // a stalled request keeps its channel until granted or withdrawn
  assign sel           = lock_q ? lock_id_q : sel_rr;
  assign l2_req_o      = lock_q ? elig[lock_id_q] : |elig;
  assign l2_addr_o     = addr_i[int'(sel)*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
  assign l2_datasize_o = datasize_i[int'(sel)*2 +: 2];
  assign hs            = l2_req_o & l2_gnt_i;
  assign gnt_o         = hs ? N_CH'(1) << sel : '0;
  assign ptr_d         = int'(sel) == N_CH - 1 ? '0 : sel + IDW'(1);
  assign head          = fifo_q[rd_q];
  assign l2_r_ready_o  = empty | r_ready_i[head];
  assign r_valid_o     = (l2_r_valid_i & ~empty) ? N_CH'(1) << head : '0;
  assign r_data_o      = l2_r_data_i;
  assign pop           = l2_r_valid_i & l2_r_ready_o & ~empty;
  assign cnt_d         = cnt_q + CW'(hs) - CW'(pop);
  assign err_d         = err_q | (l2_r_valid_i & empty);
  assign outstd_o      = cnt_q;
  assign err_o         = err_q;
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      ptr_q     <= hs ? ptr_d : ptr_q;
      lock_q    <= l2_req_o & ~l2_gnt_i;
      lock_id_q <= sel;
      wr_q      <= wr_q + PW'(hs);
      rd_q      <= rd_q + PW'(pop);
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end
  always_ff @(posedge sys_clk_i)
    if (hs) fifo_q[wr_q] <= sel;
endmodule

// File: tb/tb_udma_tx_rr_arbiter.sv
// tb_udma_tx_rr_arbiter: table-driven directed check of the round-robin L2 read arbiter
module tb_udma_tx_rr_arbiter;
  localparam int N = 4;
  localparam int W = 19;
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       gnt;
    logic       rv;
    logic [3:0] rr;
    logic       el2;
    logic [3:0] egnt;
    logic [1:0] esel;
    logic [3:0] erv;
    logic       erdy;
    logic [2:0] eout;
    logic       eerr;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0, prio = '0, rr = '0;
  logic [N*W-1:0] addr;
  logic [N*2-1:0] ds;
  logic gnt = 1'b0, rv = 1'b0;
  logic [31:0] data = '0;
  logic [N-1:0] gnt_o, r_valid_o;
  logic l2_req_o, l2_r_ready_o, err_o;
  logic [W-1:0] l2_addr_o;
  logic [1:0] l2_ds_o;
  logic [31:0] r_data_o;
  logic [2:0] outstd_o;
  int checks = 0, failures = 0;
  vec_t tv[$];
  always #5 clk = ~clk;
  udma_tx_rr_arbiter #(.N_CH(N), .L2_AWIDTH_NOAL(W), .MAX_OUTSTD(4)) dut (
    .sys_clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .datasize_i(ds),
`ifdef UDMA_ARB_PRIO_EN
    .prio_i(prio),
`endif
    .gnt_o(gnt_o), .l2_req_o(l2_req_o), .l2_addr_o(l2_addr_o), .l2_datasize_o(l2_ds_o),
    .l2_gnt_i(gnt), .l2_r_valid_i(rv), .l2_r_data_i(data), .l2_r_ready_o(l2_r_ready_o),
    .r_valid_o(r_valid_o), .r_data_o(r_data_o), .r_ready_i(rr), .outstd_o(outstd_o), .err_o(err_o)
  );
  task automatic chk(input string n, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", n, step, act, exp);
    end
  endtask
  function automatic vec_t r(int rs, int rq, int g, int v, int y, int el, int eg, int es, int ev, int ed, int eo, int ee);
    r = '{rs[0], rq[3:0], g[0], v[0], y[3:0], el[0], eg[3:0], es[1:0], ev[3:0], ed[0], eo[2:0], ee[0]};
  endfunction
  task automatic apply(input vec_t v, input int step);
    rst = v.rst; req = v.req; gnt = v.gnt; rv = v.rv; rr = v.rr; data = $urandom;
    #2;
    if (!v.rst) begin
      chk("l2_req", step, 32'(l2_req_o), 32'(v.el2));
      chk("gnt", step, 32'(gnt_o), 32'(v.egnt));
      chk("r_valid", step, 32'(r_valid_o), 32'(v.erv));
      chk("l2_r_ready", step, 32'(l2_r_ready_o), 32'(v.erdy));
      chk("outstd", step, 32'(outstd_o), 32'(v.eout));
      chk("err", step, 32'(err_o), 32'(v.eerr));
      chk("r_data", step, r_data_o, data);
      if (v.el2) begin
        chk("l2_addr", step, 32'(l2_addr_o), 32'h100 + 32'(v.esel));
        chk("l2_datasize", step, 32'(l2_ds_o), 32'(v.esel));
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int k = 0; k < N; k++) begin
      addr[k*W +: W] = W'(32'h100 + k);
      ds[k*2 +: 2] = 2'(k);
    end
    // full rotation with immediate responses, then reset-state check
    tv.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 0, 0, 0, 'hf, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 'hf, 1, 0, 'hf, 1, 'b0001, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 'hf, 1, 1, 'hf, 1, 'b0010, 1, 'b0001, 1, 1, 0));
    tv.push_back(r(0, 'hf, 1, 1, 'hf, 1, 'b0100, 2, 'b0010, 1, 1, 0));
    tv.push_back(r(0, 'hf, 1, 1, 'hf, 1, 'b1000, 3, 'b0100, 1, 1, 0));
    tv.push_back(r(0, 'hf, 1, 1, 'hf, 1, 'b0001, 0, 'b1000, 1, 1, 0));
    tv.push_back(r(0, 0, 1, 1, 'hf, 0, 0, 0, 'b0001, 1, 1, 0));
    tv.push_back(r(0, 0, 0, 0, 'hf, 0, 0, 0, 0, 1, 0, 0));
    // stalled grant keeps ch0, next grant goes to ch2
    tv.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 'b0101, 0, 0, 'hf, 1, 0, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 'b0101, 0, 0, 'hf, 1, 0, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 'b0101, 0, 0, 'hf, 1, 0, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 'b0101, 1, 0, 'hf, 1, 'b0001, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 'b0101, 1, 0, 'hf, 1, 'b0100, 2, 0, 1, 1, 0));
    tv.push_back(r(0, 0, 0, 0, 'hf, 0, 0, 0, 0, 1, 2, 0));
    // lock overrides a newly arriving earlier channel, then pointer wraps 3->0
    tv.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 'b0100, 0, 0, 'hf, 1, 0, 2, 0, 1, 0, 0));
    tv.push_back(r(0, 'b0101, 0, 0, 'hf, 1, 0, 2, 0, 1, 0, 0));
    tv.push_back(r(0, 'b0101, 1, 0, 'hf, 1, 'b0100, 2, 0, 1, 0, 0));
    tv.push_back(r(0, 'b0101, 1, 0, 'hf, 1, 'b0001, 0, 0, 1, 1, 0));
    // locked channel withdraws: no request that cycle, selection resumes after
    tv.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 'b0100, 0, 0, 'hf, 1, 0, 2, 0, 1, 0, 0));
    tv.push_back(r(0, 'b0001, 0, 0, 'hf, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 'b0001, 1, 0, 'hf, 1, 'b0001, 0, 0, 1, 0, 0));
    // fill to MAX_OUTSTD, pop reopens next cycle, drain across FIFO pointer wrap
    tv.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 'b0011, 1, 0, 'hf, 1, 'b0001, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 'b0011, 1, 0, 'hf, 1, 'b0010, 1, 0, 1, 1, 0));
    tv.push_back(r(0, 'b0011, 1, 0, 'hf, 1, 'b0001, 0, 0, 1, 2, 0));
    tv.push_back(r(0, 'b0011, 1, 0, 'hf, 1, 'b0010, 1, 0, 1, 3, 0));
    tv.push_back(r(0, 'b0011, 1, 0, 'hf, 0, 0, 0, 0, 1, 4, 0));
    tv.push_back(r(0, 'b0011, 1, 1, 'hf, 0, 0, 0, 'b0001, 1, 4, 0));
    tv.push_back(r(0, 'b0011, 1, 0, 'hf, 1, 'b0001, 0, 0, 1, 3, 0));
    tv.push_back(r(0, 0, 0, 0, 'hf, 0, 0, 0, 0, 1, 4, 0));
    tv.push_back(r(0, 0, 0, 1, 'hf, 0, 0, 0, 'b0010, 1, 4, 0));
    tv.push_back(r(0, 0, 0, 1, 'hf, 0, 0, 0, 'b0001, 1, 3, 0));
    tv.push_back(r(0, 0, 0, 1, 'hf, 0, 0, 0, 'b0010, 1, 2, 0));
    tv.push_back(r(0, 0, 0, 1, 'hf, 0, 0, 0, 'b0001, 1, 1, 0));
    tv.push_back(r(0, 0, 0, 0, 'hf, 0, 0, 0, 0, 1, 0, 0));
    // backpressured responses delivered in grant order ch1,ch0,ch1
    tv.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 'b0010, 1, 0, 'hf, 1, 'b0010, 1, 0, 1, 0, 0));
    tv.push_back(r(0, 'b0001, 1, 0, 'hf, 1, 'b0001, 0, 0, 1, 1, 0));
    tv.push_back(r(0, 'b0010, 1, 0, 'hf, 1, 'b0010, 1, 0, 1, 2, 0));
    tv.push_back(r(0, 0, 0, 1, 0, 0, 0, 0, 'b0010, 0, 3, 0));
    tv.push_back(r(0, 0, 0, 1, 'b1101, 0, 0, 0, 'b0010, 0, 3, 0));
    tv.push_back(r(0, 0, 0, 1, 'b0010, 0, 0, 0, 'b0010, 1, 3, 0));
    tv.push_back(r(0, 0, 0, 1, 'hf, 0, 0, 0, 'b0001, 1, 2, 0));
    tv.push_back(r(0, 0, 0, 1, 'hf, 0, 0, 0, 'b0010, 1, 1, 0));
    // response with empty FIFO sets sticky err, reset clears it
    tv.push_back(r(0, 0, 0, 1, 'hf, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 0, 0, 0, 'hf, 0, 0, 0, 0, 1, 0, 1));
    tv.push_back(r(0, 0, 0, 0, 'hf, 0, 0, 0, 0, 1, 0, 1));
    tv.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 0, 0, 0, 'hf, 0, 0, 0, 0, 1, 0, 0));
    // reset drops an outstanding ID; its late response is an error
    tv.push_back(r(0, 'b0001, 1, 0, 'hf, 1, 'b0001, 0, 0, 1, 0, 0));
    tv.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 0, 0, 1, 'hf, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(r(0, 0, 0, 0, 'hf, 0, 0, 0, 0, 1, 0, 1));
    for (int i = 0; i < tv.size(); i++) apply(tv[i], i);
`ifdef UDMA_ARB_PRIO_EN
    apply(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1000);
    prio = 4'b1000;
    apply(r(0, 'hf, 1, 0, 'hf, 1, 'b1000, 3, 0, 1, 0, 0), 1001);
    apply(r(0, 'hf, 1, 1, 'hf, 1, 'b1000, 3, 'b1000, 1, 1, 0), 1002);
    apply(r(0, 'hf, 1, 1, 'hf, 1, 'b1000, 3, 'b1000, 1, 1, 0), 1003);
    prio = 4'b0000;
    apply(r(0, 'hf, 1, 1, 'hf, 1, 'b0001, 0, 'b1000, 1, 1, 0), 1004);
    apply(r(0, 'hf, 1, 1, 'hf, 1, 'b0010, 1, 'b0001, 1, 1, 0), 1005);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
